exec_alu_unit: RTL and testbench
================================

Name: exec_alu_unit

Overview:
- Execute-stage arithmetic block of the single-cycle MIPS datapath.
- Merges three functions: the ALU-control decoder (ALUOp + funct → 4-bit ALU control), the 32-bit main ALU with zero flag, and the branch-target adder (PC+4 + shifted offset).
- Outputs are registered one cycle after a valid input, so the block can sit in front of the PC-select / write-back logic.

Parameters:
- WIDTH, 32, datapath width of operands, result and branch target.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies all inputs this cycle
- alu_op  input  2  ALUOp from main control
- funct  input  6  instruction bits [5:0]
- a  input  WIDTH  operand A (register rs)
- b  input  WIDTH  operand B (rt or sign-extended immediate, muxed upstream)
- pc_plus4  input  WIDTH  PC+4
- offset_shl2  input  WIDTH  sign-extended immediate already shifted left 2
- out_valid  output  1  registered in_valid
- alu_ctl  output  4  registered decoded ALU control
- result  output  WIDTH  registered ALU result
- zero  output  1  registered (result == 0)
- branch_target  output  WIDTH  registered pc_plus4 + offset_shl2
- illegal  output  1  registered: alu_op=10 with an unsupported funct
- overflow  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Decode (combinational, internal):
  - alu_op=00 → 0010 (add, lw/sw)
  - alu_op=01 → 0110 (sub, beq)
  - alu_op=11 → 0010 (add)
  - alu_op=10 decodes funct: 100000 → 0010 add; 100010 → 0110 sub; 100100 → 0000 and; 100101 → 0001 or; 101010 → 0111 slt; 100111 → 1100 nor.
  - Any other funct with alu_op=10 → ctl 1111, illegal=1.
- ALU ops (combinational, internal):
  - 0000: a & b
  - 0001: a | b
  - 0010: a + b, mod 2^WIDTH
  - 0110: a − b, mod 2^WIDTH
  - 0111: 1 if signed a < signed b, else 0
  - 1100: ~(a | b)
  - 1111 / any other code: 0
- zero = 1 iff the combinational result is all zeros; this includes the illegal case (result 0 → zero=1).
- branch_target = pc_plus4 + offset_shl2, mod 2^WIDTH, wraps silently, no carry out.
- Register stage, latency 1:
  - On a rising clock edge with in_valid=1: alu_ctl, result, zero, branch_target, illegal and overflow load their new values.
  - With in_valid=0 those registers hold.
  - out_valid loads in_valid every cycle.
- Reset (reset_n=0, asynchronous, immediate): every output register clears to 0, including out_valid, zero, illegal and overflow. Reset has priority over a simultaneous valid input.
- Release of reset is synchronous to the next rising edge. The first capture is on the first edge with reset_n=1 and in_valid=1.
- Back-to-back valid inputs produce back-to-back outputs; there is no stall or backpressure.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - For add (0010): overflow = 1 when a and b have the same sign and the result sign differs.
  - For sub (0110): overflow = 1 when a and b differ in sign and the result sign differs from a.
  - Otherwise overflow = 0.
  - Registered with the other outputs.
- Undefined: the overflow port still exists and is tied to constant 0; no overflow logic is synthesised.

Test Plan:
- Reset: hold reset_n=0 mid-stream with in_valid=1 → all outputs 0 immediately, asynchronously; after release, first valid input appears one edge later.
- R-type: alu_op=10, funct=100000, a=7, b=5 → next edge result=12, alu_ctl=0010, zero=0, out_valid=1. Then funct=101010, a=0xFFFFFFFF, b=1 → result=1 (signed −1 < 1).
- Branch compare: alu_op=01, a=b=0x1234 → result=0, zero=1. Same cycle pc_plus4=0x00000040, offset_shl2=0xFFFFFFF0 → branch_target=0x00000030.
- Logic ops: alu_op=10, a=0xF0F0F0F0, b=0x0FF00FF0:
  - funct=100100 → 0x00F000F0
  - funct=100101 → 0xFFF0FFF0
  - funct=100111 → 0x000F000F
- Illegal and hold:
  - alu_op=10, funct=000000 → alu_ctl=1111, result=0, zero=1, illegal=1.
  - Then in_valid=0 for 3 cycles → outputs hold, out_valid=0.
- Overflow (ALU_OVERFLOW_EN): alu_op=00, a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1. Without the macro, overflow=0.

Source files
------------

// File: rtl/exec_alu_if.sv
// Execute-stage ALU bundle: qualified operands toward the ALU, registered results back.
// The slave side is the ALU itself; the master side drives operands and consumes results.
interface exec_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] offset_shl2;

    logic             out_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] branch_target;
    logic             illegal;
    logic             overflow;

    modport master (
        output in_valid, alu_op, funct, a, b, pc_plus4, offset_shl2,
        input  out_valid, alu_ctl, result, zero, branch_target, illegal, overflow
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, pc_plus4, offset_shl2,
        output out_valid, alu_ctl, result, zero, branch_target, illegal, overflow
    );
endinterface

// File: rtl/exec_alu_unit.sv
// MIPS execute stage: ALU-control decode, 32-bit ALU with zero flag, branch-target adder, one register stage.
// Optional macro ALU_OVERFLOW_EN enables the signed add/sub overflow flag; otherwise overflow is tied to 0.
module exec_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset_n,
    exec_alu_if.slave io
);
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_BAD = 4'b1111;

    logic [3:0]       ctlComb;
    logic             illegalComb;
    logic [WIDTH-1:0] sumAB;
    logic [WIDTH-1:0] diffAB;
    logic [WIDTH-1:0] resultComb;
    logic [WIDTH-1:0] targetComb;

    logic             outValidReg;
    logic [3:0]       aluCtlReg;
    logic [WIDTH-1:0] resultReg;
    logic             zeroReg;
    logic [WIDTH-1:0] branchTargetReg;
    logic             illegalReg;

    always_comb begin
        ctlComb     = CTL_ADD;
        illegalComb = 1'b0;
        unique case (io.alu_op)
            2'b00: ctlComb = CTL_ADD;
            2'b01: ctlComb = CTL_SUB;
            2'b11: ctlComb = CTL_ADD;
            default: begin
                case (io.funct)
                    6'b100000: ctlComb = CTL_ADD;
                    6'b100010: ctlComb = CTL_SUB;
                    6'b100100: ctlComb = CTL_AND;
                    6'b100101: ctlComb = CTL_OR;
                    6'b101010: ctlComb = CTL_SLT;
                    6'b100111: ctlComb = CTL_NOR;
                    default: begin
                        ctlComb     = CTL_BAD;
                        illegalComb = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign sumAB      = io.a + io.b;
    assign diffAB     = io.a - io.b;
    assign targetComb = io.pc_plus4 + io.offset_shl2;

    always_comb begin
        resultComb = '0;
        case (ctlComb)
            CTL_AND: resultComb = io.a & io.b;
            CTL_OR:  resultComb = io.a | io.b;
            CTL_ADD: resultComb = sumAB;
            CTL_SUB: resultComb = diffAB;
            CTL_SLT: resultComb = {{(WIDTH-1){1'b0}}, ($signed(io.a) < $signed(io.b))};
            CTL_NOR: resultComb = ~(io.a | io.b);
            default: resultComb = '0;
        endcase
    end

    // Capture registers load only on valid input; out_valid tracks in_valid every edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outValidReg     <= 1'b0;
            aluCtlReg       <= '0;
            resultReg       <= '0;
            zeroReg         <= 1'b0;
            branchTargetReg <= '0;
            illegalReg      <= 1'b0;
        end else begin
            outValidReg <= io.in_valid;
            if (io.in_valid) begin
                aluCtlReg       <= ctlComb;
                resultReg       <= resultComb;
                zeroReg         <= (resultComb == '0);
                branchTargetReg <= targetComb;
                illegalReg      <= illegalComb;
            end
        end
    end

    assign io.out_valid     = outValidReg;
    assign io.alu_ctl       = aluCtlReg;
    assign io.result        = resultReg;
    assign io.zero          = zeroReg;
    assign io.branch_target = branchTargetReg;
    assign io.illegal       = illegalReg;

`ifdef ALU_OVERFLOW_EN
    logic overflowComb;
    logic overflowReg;

    always_comb begin
        overflowComb = 1'b0;
        if (ctlComb == CTL_ADD)
            overflowComb = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (sumAB[WIDTH-1] != io.a[WIDTH-1]);
        else if (ctlComb == CTL_SUB)
            overflowComb = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (diffAB[WIDTH-1] != io.a[WIDTH-1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            overflowReg <= 1'b0;
        else if (io.in_valid)
            overflowReg <= overflowComb;
    end

    assign io.overflow = overflowReg;
`else
    assign io.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed self-checking bench for exec_alu_unit; overflow expectations follow ALU_OVERFLOW_EN.
module tb_exec_alu_unit;
    logic clock;
    logic reset_n;
    int   passCount;
    int   totalCount;
    logic ovfOn;

    exec_alu_if #(.WIDTH(32)) bus ();

    exec_alu_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] pc, input logic [31:0] off);
        bus.in_valid    = v;
        bus.alu_op      = op;
        bus.funct       = fn;
        bus.a           = av;
        bus.b           = bv;
        bus.pc_plus4    = pc;
        bus.offset_shl2 = off;
    endtask

    // One transaction: apply inputs, pass one rising edge, sample 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [3:0] ctl,
                            input logic [31:0] res, input logic z, input logic [31:0] bt,
                            input logic ill, input logic ovf);
        check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        check({tag, ".alu_ctl"}, {28'b0, bus.alu_ctl}, {28'b0, ctl});
        check({tag, ".result"}, bus.result, res);
        check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, z});
        check({tag, ".branch_target"}, bus.branch_target, bt);
        check({tag, ".illegal"}, {31'b0, bus.illegal}, {31'b0, ill});
        check({tag, ".overflow"}, {31'b0, bus.overflow}, {31'b0, ovf});
        $display("txn %-10s valid=%0d ctl=%04b result=0x%08h zero=%0d bt=0x%08h illegal=%0d ovf=%0d",
                 tag, bus.out_valid, bus.alu_ctl, bus.result, bus.zero, bus.branch_target,
                 bus.illegal, bus.overflow);
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
`ifdef ALU_OVERFLOW_EN
        ovfOn = 1'b1;
`else
        ovfOn = 1'b0;
`endif
        reset_n = 1'b0;
        drive(1'b1, 2'b10, 6'b100000, 32'd7, 32'd5, 32'h100, 32'h4);
        cycle();
        checkOut("reset", 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Release mid-cycle; the next edge is the first capture.
        reset_n = 1'b1;
        cycle();
        checkOut("add", 1'b1, 4'b0010, 32'd12, 1'b0, 32'h104, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        cycle();
        checkOut("slt", 1'b1, 4'b0111, 32'd1, 1'b0, 32'h0, 1'b0, 1'b0);

        drive(1'b1, 2'b01, 6'b000000, 32'h1234, 32'h1234, 32'h40, 32'hFFFF_FFF0);
        cycle();
        checkOut("beq", 1'b1, 4'b0110, 32'h0, 1'b1, 32'h30, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h8, 32'h8);
        cycle();
        checkOut("and", 1'b1, 4'b0000, 32'h00F0_00F0, 1'b0, 32'h10, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h8, 32'h8);
        cycle();
        checkOut("or", 1'b1, 4'b0001, 32'hFFF0_FFF0, 1'b0, 32'h10, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h8, 32'h8);
        cycle();
        checkOut("nor", 1'b1, 4'b1100, 32'h000F_000F, 1'b0, 32'h10, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFC, 32'h8);
        cycle();
        checkOut("sub_wrap", 1'b1, 4'b0110, 32'hFFFF_FFFE, 1'b0, 32'h4, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b000000, 32'd9, 32'd3, 32'h20, 32'h4);
        cycle();
        checkOut("illegal", 1'b1, 4'b1111, 32'h0, 1'b1, 32'h24, 1'b1, 1'b0);

        // Idle inputs change freely; captured outputs must not move.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 6'b100000, 32'd100 + i, 32'd1, 32'h500, 32'h500);
            cycle();
            checkOut("hold", 1'b0, 4'b1111, 32'h0, 1'b1, 32'h24, 1'b1, 1'b0);
        end

        drive(1'b1, 2'b11, 6'b111111, 32'd3, 32'd4, 32'h0, 32'h0);
        cycle();
        checkOut("op11_add", 1'b1, 4'b0010, 32'd7, 1'b0, 32'h0, 1'b0, 1'b0);

        drive(1'b1, 2'b00, 6'b000000, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0);
        cycle();
        checkOut("add_ovf", 1'b1, 4'b0010, 32'h8000_0000, 1'b0, 32'h0, 1'b0, ovfOn);

        drive(1'b1, 2'b01, 6'b000000, 32'h8000_0000, 32'd1, 32'h0, 32'h0);
        cycle();
        checkOut("sub_ovf", 1'b1, 4'b0110, 32'h7FFF_FFFF, 1'b0, 32'h0, 1'b0, ovfOn);

        drive(1'b1, 2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        cycle();
        checkOut("add_noovf", 1'b1, 4'b0010, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

        drive(1'b1, 2'b10, 6'b100000, 32'd20, 32'd22, 32'h1000, 32'h10);
        cycle();
        checkOut("pre_rst", 1'b1, 4'b0010, 32'd42, 1'b0, 32'h1010, 1'b0, 1'b0);

        // Asynchronous reset between edges with valid input still applied.
        #2;
        reset_n = 1'b0;
        #1;
        checkOut("async_rst", 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        checkOut("rst_hold", 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        #2;
        reset_n = 1'b1;
        cycle();
        checkOut("post_rst", 1'b1, 4'b0010, 32'd42, 1'b0, 32'h1010, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
